// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared opcode, ALU-command and branch encodings plus the decoded-control struct
// used by decode_ctrl_pipe and its opcode decoder.
package decode_ctrl_pipe_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_AND = 4'd4;
  localparam logic [3:0] CMD_OR  = 4'd5;
  localparam logic [3:0] CMD_NOR = 4'd6;
  localparam logic [3:0] CMD_XOR = 4'd7;
  localparam logic [3:0] CMD_SHL = 4'd8;
  localparam logic [3:0] CMD_SRA = 4'd9;
  localparam logic [3:0] CMD_SRL = 4'd10;

  typedef enum logic [1:0] {
    BT_NONE = 2'b00,
    BT_BEZ  = 2'b01,
    BT_BNE  = 2'b10,
    BT_JMP  = 2'b11
  } branch_t;

  typedef struct packed {
    branch_t    branch_type;
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       writeback_en;
    logic       is_immediate;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{
    branch_type:  BT_NONE,
    exe_cmd:      4'd0,
    mem_read:     1'b0,
    mem_write:    1'b0,
    writeback_en: 1'b0,
    is_immediate: 1'b0
  };

  // Register-writing ALU op; memory and branch bits stay clear.
  function automatic ctrl_t alu_ctrl(input logic [3:0] cmd, input logic imm);
    ctrl_t c;
    c              = CTRL_NONE;
    c.exe_cmd      = cmd;
    c.writeback_en = 1'b1;
    c.is_immediate = imm;
    return c;
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_opcode_decode.sv
// Pure combinational opcode decoder: control struct, illegal flag and
// which register sources the instruction reads.
module decode_ctrl_pipe_opcode_decode
  import decode_ctrl_pipe_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                illegal,
  output logic                use_src1,
  output logic                use_src2
);

  always_comb begin
    ctrl     = CTRL_NONE;
    illegal  = 1'b0;
    use_src1 = 1'b1;
    use_src2 = 1'b0;
    case (opcode)
      OPCODE_W'(OP_NOP):  use_src1 = 1'b0;
      OPCODE_W'(OP_ADD):  begin ctrl = alu_ctrl(CMD_ADD, 1'b0); use_src2 = 1'b1; end
      OPCODE_W'(OP_SUB):  begin ctrl = alu_ctrl(CMD_SUB, 1'b0); use_src2 = 1'b1; end
      OPCODE_W'(OP_AND):  begin ctrl = alu_ctrl(CMD_AND, 1'b0); use_src2 = 1'b1; end
      OPCODE_W'(OP_OR):   begin ctrl = alu_ctrl(CMD_OR,  1'b0); use_src2 = 1'b1; end
      OPCODE_W'(OP_NOR):  begin ctrl = alu_ctrl(CMD_NOR, 1'b0); use_src2 = 1'b1; end
      OPCODE_W'(OP_XOR):  begin ctrl = alu_ctrl(CMD_XOR, 1'b0); use_src2 = 1'b1; end
      OPCODE_W'(OP_SLA):  begin ctrl = alu_ctrl(CMD_SHL, 1'b0); use_src2 = 1'b1; end
      OPCODE_W'(OP_SLL):  begin ctrl = alu_ctrl(CMD_SHL, 1'b0); use_src2 = 1'b1; end
      OPCODE_W'(OP_SRA):  begin ctrl = alu_ctrl(CMD_SRA, 1'b0); use_src2 = 1'b1; end
      OPCODE_W'(OP_SRL):  begin ctrl = alu_ctrl(CMD_SRL, 1'b0); use_src2 = 1'b1; end
      OPCODE_W'(OP_ADDI): ctrl = alu_ctrl(CMD_ADD, 1'b1);
      OPCODE_W'(OP_SUBI): ctrl = alu_ctrl(CMD_SUB, 1'b1);
      OPCODE_W'(OP_LD):   begin ctrl = alu_ctrl(CMD_ADD, 1'b1); ctrl.mem_read = 1'b1; end
      OPCODE_W'(OP_ST): begin
        ctrl.is_immediate = 1'b1;
        ctrl.mem_write    = 1'b1;
        use_src2          = 1'b1;
      end
      OPCODE_W'(OP_BEZ): begin
        ctrl.branch_type  = BT_BEZ;
        ctrl.is_immediate = 1'b1;
      end
      OPCODE_W'(OP_BNE): begin
        ctrl.branch_type  = BT_BNE;
        ctrl.is_immediate = 1'b1;
        use_src2          = 1'b1;
      end
      OPCODE_W'(OP_JMP): begin
        ctrl.branch_type  = BT_JMP;
        ctrl.is_immediate = 1'b1;
        use_src1          = 1'b0;
      end
      // Undefined opcodes still occupy a slot; src1 is treated as read.
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered ID/EX decode controller with valid/ready handshake, load-use bubble,
// flush and saturating stall counter. Optional sticky trap: CTRL_ILLEGAL_TRAP_EN.
module decode_ctrl_pipe
  import decode_ctrl_pipe_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int EXE_CMD_W  = 4,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            branch_type,
  output logic [EXE_CMD_W-1:0]  exe_cmd,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  writeback_en,
  output logic                  is_immediate,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic                  illegal,
  output logic [CNT_W-1:0]      stall_cnt
);

  ctrl_t                  dec_ctrl;
  ctrl_t                  dec_fixed;
  logic                   dec_illegal;
  logic                   use_src1;
  logic                   use_src2;

  ctrl_t                  ctrl_q;
  logic                   out_valid_q;
  logic                   illegal_q;
  logic [REG_ADDR_W-1:0]  dest_q;
  logic [CNT_W-1:0]       stall_q;

  logic                   hazard;
  logic                   load;
  logic                   accept;
  logic                   issue_block;

  decode_ctrl_pipe_opcode_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .opcode   (opcode),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .use_src1 (use_src1),
    .use_src2 (use_src2)
  );

  // r0 is hardwired zero, so never write it back.
  always_comb begin
    dec_fixed = dec_ctrl;
    if (dest == '0) dec_fixed.writeback_en = 1'b0;
  end

  assign hazard = out_valid_q & ctrl_q.mem_read & in_valid & (dest_q != '0) &
                  ((use_src1 & (src1 == dest_q)) | (use_src2 & (src2 == dest_q)));

  assign load     = ~out_valid_q | out_ready;
  assign in_ready = rst & load & ~hazard & ~flush & ~issue_block;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= CTRL_NONE;
      illegal_q   <= 1'b0;
      dest_q      <= '0;
      stall_q     <= '0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
        ctrl_q      <= CTRL_NONE;
        illegal_q   <= 1'b0;
        dest_q      <= '0;
      end else if (load) begin
        if (accept) begin
          out_valid_q <= 1'b1;
          ctrl_q      <= dec_fixed;
          illegal_q   <= dec_illegal;
          dest_q      <= dest;
        end else begin
          out_valid_q <= 1'b0;
          ctrl_q      <= CTRL_NONE;
          illegal_q   <= 1'b0;
          dest_q      <= '0;
        end
      end
      if (hazard && !flush && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic trap_q;

  // Trap arms only when EX actually consumes the illegal slot (not when it is flushed).
  always_ff @(posedge clk) begin
    if (!rst) trap_q <= 1'b0;
    else if (out_valid_q && illegal_q && out_ready && !flush) trap_q <= 1'b1;
  end

  assign issue_block = trap_q;
  assign illegal     = illegal_q | trap_q;
`else
  assign issue_block = 1'b0;
  assign illegal     = illegal_q;
`endif

  assign out_valid    = out_valid_q;
  assign branch_type  = ctrl_q.branch_type;
  assign exe_cmd      = EXE_CMD_W'(ctrl_q.exe_cmd);
  assign mem_read     = ctrl_q.mem_read;
  assign mem_write    = ctrl_q.mem_write;
  assign writeback_en = ctrl_q.writeback_en;
  assign is_immediate = ctrl_q.is_immediate;
  assign dest_out     = dest_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed plus randomized bench for decode_ctrl_pipe against a table-driven
// slot model; follows CTRL_ILLEGAL_TRAP_EN when the build defines it.
module tb_decode_ctrl_pipe;

  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic [4:0] src1 = '0;
  logic [4:0] src2 = '0;
  logic [4:0] dest = '0;

  logic          in_ready;
  logic          out_valid;
  logic [1:0]    branch_type;
  logic [3:0]    exe_cmd;
  logic          mem_read;
  logic          mem_write;
  logic          writeback_en;
  logic          is_immediate;
  logic [4:0]    dest_out;
  logic          illegal;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] bt;
    logic [3:0] cmd;
    logic mr, mw, wb, imm, ill, s1, s2;
  } dec_t;

  bit         m_valid = 0;
  dec_t       m_d;
  logic [4:0] m_dest = '0;
  int         m_stall = 0;
  bit         m_trap = 0;

  decode_ctrl_pipe #(
    .OPCODE_W   (6),
    .EXE_CMD_W  (4),
    .REG_ADDR_W (5),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .src1         (src1),
    .src2         (src2),
    .dest         (dest),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .branch_type  (branch_type),
    .exe_cmd      (exe_cmd),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .writeback_en (writeback_en),
    .is_immediate (is_immediate),
    .dest_out     (dest_out),
    .illegal      (illegal),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic dec_t blank();
    dec_t d = '{default: 0};
    return d;
  endfunction

  // Opcode table written straight from the instruction map.
  function automatic dec_t ref_decode(input logic [5:0] op);
    dec_t d = '{default: 0};
    d.s1 = 1;
    case (op)
      0:  d.s1 = 0;
      1:  begin d.cmd = 0;  d.wb = 1; d.s2 = 1; end
      3:  begin d.cmd = 2;  d.wb = 1; d.s2 = 1; end
      5:  begin d.cmd = 4;  d.wb = 1; d.s2 = 1; end
      6:  begin d.cmd = 5;  d.wb = 1; d.s2 = 1; end
      7:  begin d.cmd = 6;  d.wb = 1; d.s2 = 1; end
      8:  begin d.cmd = 7;  d.wb = 1; d.s2 = 1; end
      9:  begin d.cmd = 8;  d.wb = 1; d.s2 = 1; end
      10: begin d.cmd = 8;  d.wb = 1; d.s2 = 1; end
      11: begin d.cmd = 9;  d.wb = 1; d.s2 = 1; end
      12: begin d.cmd = 10; d.wb = 1; d.s2 = 1; end
      32: begin d.cmd = 0; d.wb = 1; d.imm = 1; end
      33: begin d.cmd = 2; d.wb = 1; d.imm = 1; end
      36: begin d.cmd = 0; d.wb = 1; d.imm = 1; d.mr = 1; end
      37: begin d.imm = 1; d.mw = 1; d.s2 = 1; end
      40: begin d.bt = 2'b01; d.imm = 1; end
      41: begin d.bt = 2'b10; d.imm = 1; d.s2 = 1; end
      42: begin d.bt = 2'b11; d.imm = 1; d.s1 = 0; end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit iv, input int op, input int s1, input int s2,
                       input int d, input bit fl, input bit ordy);
    dec_t e;
    bit   haz;
    bit   rdy;
    @(negedge clk);
    rst = r; in_valid = iv; opcode = op[5:0]; src1 = s1[4:0]; src2 = s2[4:0];
    dest = d[4:0]; flush = fl; out_ready = ordy;
    #1;
    e   = ref_decode(op[5:0]);
    haz = m_valid && m_d.mr && iv && (m_dest != 0) &&
          ((e.s1 && s1[4:0] == m_dest) || (e.s2 && s2[4:0] == m_dest));
    rdy = r && (!m_valid || ordy) && !haz && !fl && !m_trap;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clk);
    if (!r) begin
      m_valid = 0; m_d = blank(); m_dest = 0; m_stall = 0; m_trap = 0;
    end else begin
      if (haz && !fl && m_stall < (1 << CW) - 1) m_stall++;
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (m_valid && m_d.ill && ordy && !fl) m_trap = 1;
`endif
      if (fl) begin
        m_valid = 0; m_d = blank(); m_dest = 0;
      end else if (!m_valid || ordy) begin
        if (iv && rdy) begin
          m_valid = 1; m_d = e; m_dest = d[4:0];
          if (d[4:0] == 0) m_d.wb = 0;
        end else begin
          m_valid = 0; m_d = blank(); m_dest = 0;
        end
      end
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("ctrl", {22'd0, branch_type, exe_cmd, mem_read, mem_write, writeback_en, is_immediate},
        {22'd0, m_d.bt, m_d.cmd, m_d.mr, m_d.mw, m_d.wb, m_d.imm});
    chk("dest_out", {27'd0, dest_out}, {27'd0, m_dest});
    chk("illegal", {31'd0, illegal}, {31'd0, m_d.ill | m_trap});
    chk("stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, m_stall);
  endtask

  int ops[21] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42, 63, 2, 50};

  initial begin
    m_d = blank();
    // reset
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 2, 3, 0, 1);
    // ADD dest=3
    cycle(1, 1, 1, 1, 2, 3, 0, 1);
    // LD dest=4 then dependent ADD: one bubble, then issue
    cycle(1, 1, 36, 1, 0, 4, 0, 1);
    cycle(1, 1, 1, 4, 2, 5, 0, 1);
    cycle(1, 1, 1, 4, 2, 5, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    // LD to r0 then ADD reading r0: no stall
    cycle(1, 1, 36, 1, 0, 0, 0, 1);
    cycle(1, 1, 1, 0, 0, 6, 0, 1);
    // SUBI held under backpressure
    cycle(1, 1, 33, 1, 0, 7, 0, 1);
    repeat (3) cycle(1, 1, 33, 2, 0, 8, 0, 0);
    cycle(1, 1, 33, 2, 0, 8, 0, 1);
    // flush with BNE on input and LD in output slot
    cycle(1, 1, 36, 1, 0, 9, 0, 1);
    cycle(1, 1, 41, 9, 9, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    // illegal opcode
    cycle(1, 1, 63, 1, 1, 10, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) cycle(1, 1, 1, 1, 2, 3, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // stall counter saturation, then reset mid-stall
    cycle(1, 1, 36, 1, 0, 5, 0, 1);
    repeat (18) cycle(1, 1, 1, 5, 2, 6, 0, 0);
    cycle(0, 1, 1, 5, 2, 6, 0, 0);
    cycle(1, 1, 1, 5, 2, 6, 0, 1);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int op;
      op = ops[$urandom_range(0, 20)];
      if ($urandom_range(0, 3) == 0) op = 36;
      cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, op,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
